// File: rtl/pstk_pkg.sv
// pstk_pkg: shared FSM state type and the single-axis saturating update rule.
// The optional hold-acceleration feature is enabled by defining PSTK_ACCEL_EN.
`default_nettype none

package pstk_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Recentre beats directions; plus beats minus; release either decays toward
  // zero without overshoot (self-centring) or holds (sticky); then clamp.
  function automatic int axis_update(input int acc, input logic plus, input logic minus,
                                     input logic mode, input logic recen,
                                     input int step, input int rstep, input int limit);
    int r;
    if (recen)
      r = 0;
    else if (plus)
      r = acc + step;
    else if (minus)
      r = acc - step;
    else if (!mode) begin
      if (acc > rstep)
        r = acc - rstep;
      else if (acc < -rstep)
        r = acc + rstep;
      else
        r = 0;
    end else
      r = acc;
    if (r > limit)
      r = limit;
    else if (r < -limit)
      r = -limit;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pstk_axis.sv
// pstk_axis: combinational next-value stage for one axis of the selected channel.
// With PSTK_ACCEL_EN defined it also produces the next hold count / direction.
`default_nettype none

module pstk_axis
  import pstk_pkg::*;
#(
  parameter int AW    = 8,
  parameter int STEP  = 15,
  parameter int RSTEP = 15,
  parameter int LIMIT = 120
) (
  input  logic signed [AW+1:0] i_acc,
  input  logic                 i_plus,
  input  logic                 i_minus,
  input  logic                 i_mode,
  input  logic                 i_recen,
`ifdef PSTK_ACCEL_EN
  input  logic [2:0]           i_cnt,
  input  logic [1:0]           i_dir,
  output logic [2:0]           o_cnt,
  output logic [1:0]           o_dir,
`endif
  output logic signed [AW+1:0] o_acc
);

`ifdef PSTK_ACCEL_EN
  int w_step;

  // Direction codes: 0 = none, 1 = plus, 2 = minus; recentre counts as release.
  always_comb begin
    o_dir = 2'd0;
    o_cnt = 3'd0;
    if (!i_recen && i_plus)
      o_dir = 2'd1;
    else if (!i_recen && i_minus)
      o_dir = 2'd2;
    if (o_dir != 2'd0 && o_dir == i_dir)
      o_cnt = (i_cnt == 3'd7) ? 3'd7 : i_cnt + 3'd1;
    w_step = (o_cnt >= 3'd4) ? 2 * STEP : STEP;
  end

  assign o_acc = (AW+2)'(axis_update(int'(i_acc), i_plus, i_minus, i_mode, i_recen,
                                      w_step, RSTEP, LIMIT));
`else
  assign o_acc = (AW+2)'(axis_update(int'(i_acc), i_plus, i_minus, i_mode, i_recen,
                                      STEP, RSTEP, LIMIT));
`endif

endmodule

`default_nettype wire

// File: rtl/pseudo_ana_stk_multi.sv
// pseudo_ana_stk_multi: N-channel digital-to-pseudo-analog stick generator with a
// time-multiplexed update sequencer. Optional hold acceleration: PSTK_ACCEL_EN.
`default_nettype none

module pseudo_ana_stk_multi
  import pstk_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int AW     = 8,
  parameter int STEP   = 15,
  parameter int RSTEP  = 15,
  parameter int LIMIT  = 120,
  parameter int CENTER = 127
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              TICK,
  input  logic [NCH-1:0]    UP,
  input  logic [NCH-1:0]    DW,
  input  logic [NCH-1:0]    LF,
  input  logic [NCH-1:0]    RG,
  input  logic [NCH-1:0]    MODE,
  input  logic [NCH-1:0]    RECEN,
  output logic [NCH*AW-1:0] AX,
  output logic [NCH*AW-1:0] AY,
  output logic              BUSY
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  if (CENTER - LIMIT < 0 || CENTER + LIMIT > (1 << AW) - 1) begin : g_param_check
    $error("pseudo_ana_stk_multi: CENTER +/- LIMIT does not fit in AW bits");
  end

  state_t              r_state, w_state_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt;
  logic                r_pend, w_pend_nxt;
  logic                r_tick_q;
  logic signed [AW+1:0] r_accx [NCH];
  logic signed [AW+1:0] r_accy [NCH];
  logic [NCH*AW-1:0]   r_ax, r_ay;
  logic signed [AW+1:0] w_nx, w_ny;
  logic                w_edge, w_run, w_last;

  assign w_edge = TICK & ~r_tick_q;
  assign w_run  = (r_state == ST_RUN);
  assign w_last = (r_idx == IW'(NCH - 1));
  assign BUSY   = w_run;
  assign AX     = r_ax;
  assign AY     = r_ay;

  // One level of pending: an edge during RUN is remembered, later ones are dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pend_nxt  = r_pend;
    case (r_state)
      ST_IDLE: begin
        if (w_edge) begin
          w_state_nxt = ST_RUN;
          w_idx_nxt   = '0;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_idx_nxt  = '0;
          w_pend_nxt = 1'b0;
          if (!(r_pend || w_edge))
            w_state_nxt = ST_IDLE;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
          if (w_edge)
            w_pend_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef PSTK_ACCEL_EN
  logic [2:0] r_cntx [NCH];
  logic [2:0] r_cnty [NCH];
  logic [1:0] r_dirx [NCH];
  logic [1:0] r_diry [NCH];
  logic [2:0] w_cntx, w_cnty;
  logic [1:0] w_dirx, w_diry;
`endif

  pstk_axis #(.AW(AW), .STEP(STEP), .RSTEP(RSTEP), .LIMIT(LIMIT)) u_axis_x (
    .i_acc   (r_accx[r_idx]),
    .i_plus  (LF[r_idx]),
    .i_minus (RG[r_idx]),
    .i_mode  (MODE[r_idx]),
    .i_recen (RECEN[r_idx]),
`ifdef PSTK_ACCEL_EN
    .i_cnt   (r_cntx[r_idx]),
    .i_dir   (r_dirx[r_idx]),
    .o_cnt   (w_cntx),
    .o_dir   (w_dirx),
`endif
    .o_acc   (w_nx)
  );

  pstk_axis #(.AW(AW), .STEP(STEP), .RSTEP(RSTEP), .LIMIT(LIMIT)) u_axis_y (
    .i_acc   (r_accy[r_idx]),
    .i_plus  (UP[r_idx]),
    .i_minus (DW[r_idx]),
    .i_mode  (MODE[r_idx]),
    .i_recen (RECEN[r_idx]),
`ifdef PSTK_ACCEL_EN
    .i_cnt   (r_cnty[r_idx]),
    .i_dir   (r_diry[r_idx]),
    .o_cnt   (w_cnty),
    .o_dir   (w_diry),
`endif
    .o_acc   (w_ny)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_pend   <= 1'b0;
      r_tick_q <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        r_accx[k]           <= '0;
        r_accy[k]           <= '0;
        r_ax[k*AW +: AW]    <= AW'(CENTER);
        r_ay[k*AW +: AW]    <= AW'(CENTER);
`ifdef PSTK_ACCEL_EN
        r_cntx[k] <= '0;
        r_cnty[k] <= '0;
        r_dirx[k] <= '0;
        r_diry[k] <= '0;
`endif
      end
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_pend   <= w_pend_nxt;
      r_tick_q <= TICK;
      if (w_run) begin
        r_accx[r_idx]          <= w_nx;
        r_accy[r_idx]          <= w_ny;
        r_ax[r_idx*AW +: AW]   <= AW'(w_nx + CENTER);
        r_ay[r_idx*AW +: AW]   <= AW'(w_ny + CENTER);
`ifdef PSTK_ACCEL_EN
        r_cntx[r_idx] <= w_cntx;
        r_cnty[r_idx] <= w_cnty;
        r_dirx[r_idx] <= w_dirx;
        r_diry[r_idx] <= w_diry;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pseudo_ana_stk_multi.sv
// tb_pseudo_ana_stk_multi: directed + random ticks checked against a magnitude-based
// stick model. Honours PSTK_ACCEL_EN to match the DUT build.
`default_nettype none

module tb_pseudo_ana_stk_multi;

  localparam int NCH    = 4;
  localparam int AW     = 8;
  localparam int STEP   = 15;
  localparam int RSTEP  = 15;
  localparam int LIMIT  = 120;
  localparam int CENTER = 127;

  logic              CLK = 1'b0;
  logic              RESET, TICK;
  logic [NCH-1:0]    UP, DW, LF, RG, MODE, RECEN;
  logic [NCH*AW-1:0] AX, AY;
  logic              BUSY;

  int ncmp = 0;
  int nfail = 0;
  int mx[NCH], my[NCH];
  int cx[NCH], cy[NCH], dx[NCH], dy[NCH];

  pseudo_ana_stk_multi #(.NCH(NCH), .AW(AW), .STEP(STEP), .RSTEP(RSTEP),
                         .LIMIT(LIMIT), .CENTER(CENTER)) dut (
    .CLK(CLK), .RESET(RESET), .TICK(TICK), .UP(UP), .DW(DW), .LF(LF), .RG(RG),
    .MODE(MODE), .RECEN(RECEN), .AX(AX), .AY(AY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Position model: held direction moves, release shrinks magnitude (floored at 0).
  function automatic int mstep(int acc, bit p, bit m, bit mode, bit rc, int step);
    int v, mag;
    if (rc) return 0;
    if (p) v = acc + step;
    else if (m) v = acc - step;
    else if (mode) v = acc;
    else begin
      mag = (acc < 0 ? -acc : acc) - RSTEP;
      if (mag < 0) mag = 0;
      v = (acc < 0) ? -mag : mag;
    end
    if (v > LIMIT) v = LIMIT;
    if (v < -LIMIT) v = -LIMIT;
    return v;
  endfunction

  task automatic mstepsize(inout int cnt, inout int dir, input bit p, input bit m,
                           input bit rc, output int step);
    int d;
    d = rc ? 0 : (p ? 1 : (m ? 2 : 0));
    if (d == 0 || d != dir) cnt = 0;
    else cnt = (cnt >= 7) ? 7 : cnt + 1;
    dir = d;
`ifdef PSTK_ACCEL_EN
    step = (cnt >= 4) ? 2 * STEP : STEP;
`else
    step = STEP;
`endif
  endtask

  task automatic model_pass();
    int sx, sy;
    for (int k = 0; k < NCH; k++) begin
      mstepsize(cx[k], dx[k], LF[k], RG[k], RECEN[k], sx);
      mstepsize(cy[k], dy[k], UP[k], DW[k], RECEN[k], sy);
      mx[k] = mstep(mx[k], LF[k], RG[k], MODE[k], RECEN[k], sx);
      my[k] = mstep(my[k], UP[k], DW[k], MODE[k], RECEN[k], sy);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      mx[k] = 0; my[k] = 0; cx[k] = 0; cy[k] = 0; dx[k] = 0; dy[k] = 0;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(string tag);
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("%s ax%0d", tag, k), 32'(AX[k*AW +: AW]), 32'((mx[k] + CENTER) & 255));
      chk($sformatf("%s ay%0d", tag, k), 32'(AY[k*AW +: AW]), 32'((my[k] + CENTER) & 255));
    end
  endtask

  task automatic do_tick(string tag);
    int nb;
    TICK = 1'b1;
    @(negedge CLK);
    TICK = 1'b0;
    nb = 0;
    for (int c = 0; c < 64; c++) begin
      if (BUSY) nb++;
      else break;
      @(negedge CLK);
    end
    chk({tag, " busy_cycles"}, 32'(nb), 32'(NCH));
    model_pass();
    chk_outs(tag);
    @(negedge CLK);
  endtask

  initial begin
    int nb;
    RESET = 1'b1; TICK = 1'b0;
    UP = '0; DW = '0; LF = '0; RG = '0; MODE = '0; RECEN = '0;
    model_reset();
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    chk("reset busy", 32'(BUSY), 32'd0);
    chk_outs("reset");

    repeat (3) do_tick("idle");

    LF[0] = 1'b1;
    repeat (10) do_tick("ch0 left");
    LF[0] = 1'b0;
    repeat (8) do_tick("ch0 return");

    MODE[1] = 1'b1; DW[1] = 1'b1;
    repeat (3) do_tick("ch1 sticky down");
    DW[1] = 1'b0;
    repeat (2) do_tick("ch1 sticky hold");
    RECEN[1] = 1'b1;
    do_tick("ch1 recentre");
    RECEN[1] = 1'b0; MODE[1] = 1'b0;

    LF[2] = 1'b1; RG[2] = 1'b1; UP[3] = 1'b1; DW[3] = 1'b1;
    repeat (3) do_tick("lf rg both");
    LF = '0; RG = '0; UP = '0; DW = '0;

    for (int i = 0; i < 24; i++) begin
      UP    = NCH'($urandom);
      DW    = NCH'($urandom);
      LF    = NCH'($urandom);
      RG    = NCH'($urandom);
      MODE  = NCH'($urandom);
      RECEN = NCH'($urandom & $urandom & $urandom);
      do_tick("random");
    end
    RECEN = '0;

    // Three edges two cycles apart: second is pended, third is dropped.
    LF = '1; UP = '0; DW = '0; RG = '0; MODE = '0;
    nb = 0;
    TICK = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      TICK = (c == 1 || c == 3);
      if (BUSY) nb++;
    end
    chk("rapid busy_cycles", 32'(nb), 32'(2 * NCH));
    model_pass();
    model_pass();
    chk_outs("rapid");

    TICK = 1'b1;
    @(negedge CLK);
    TICK = 1'b0;
    @(negedge CLK);
    chk("midrun busy", 32'(BUSY), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    model_reset();
    chk("reset midrun busy", 32'(BUSY), 32'd0);
    chk_outs("reset midrun");
    RESET = 1'b0;
    LF = '0;
    @(negedge CLK);
    UP[0] = 1'b1;
    do_tick("after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

`default_nettype wire
